// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite bus bundle between the register-file slave and its master.
// Clock and reset are kept outside the bundle as plain ports.
interface axi_lite_slave_regs_if #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
);

  // Write address channel
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr;
  logic [2:0]                    awprot;
  logic                          awvalid;
  logic                          awready;

  // Write data channel
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata;
  logic                          wvalid;
  logic                          wready;

  // Write response channel
  logic [1:0]                    bresp;
  logic                          bvalid;
  logic                          bready;

  // Read address channel
  logic [C_S_AXI_ADDR_WIDTH-1:0] araddr;
  logic [2:0]                    arprot;
  logic                          arvalid;
  logic                          arready;

  // Read data channel
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata;
  logic [1:0]                    rresp;
  logic                          rvalid;
  logic                          rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave register file: three R/W registers plus a read-only
// status word {wr_cnt, rd_cnt}. Register 0 is exported as ctrl_out.
// Write and read channels are independent, one outstanding transaction each.
module axi_lite_slave_regs #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  axi_lite_slave_regs_if.slave          bus,
  output logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_out
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] IdxStatus  = 2'd3;

  // Ready gate: holds the slave off for the first cycle after reset release.
  logic en_q;

  // Write path state
  logic          aw_full_q;
  logic          w_full_q;
  logic [1:0]    aw_idx_q;
  logic [DW-1:0] wdata_q;
  logic          bvalid_q;
  logic [1:0]    bresp_q;

  // Read path state
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;

  // Register file and transaction counters
  logic [DW-1:0] reg0_q;
  logic [DW-1:0] reg1_q;
  logic [DW-1:0] reg2_q;
  logic [15:0]   wr_cnt_q;
  logic [15:0]   rd_cnt_q;

  logic          aw_hs;
  logic          w_hs;
  logic          ar_hs;
  logic          commit;
  logic [DW-1:0] rd_mux;

  // Protection bits and byte offset carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{bus.awprot, bus.arprot, bus.awaddr[1:0], bus.araddr[1:0]};

  assign bus.awready = en_q & ~aw_full_q & ~bvalid_q;
  assign bus.wready  = en_q & ~w_full_q & ~bvalid_q;
  assign bus.arready = en_q & ~rvalid_q;

  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = RespOkay;

  assign ctrl_out    = reg0_q;

  assign aw_hs  = bus.awvalid & bus.awready;
  assign w_hs   = bus.wvalid & bus.wready;
  assign ar_hs  = bus.arvalid & bus.arready;
  // Both halves latched and the response slot free.
  assign commit = aw_full_q & w_full_q & ~bvalid_q;

  // Read data select; uses pre-edge register values so a same-edge write
  // commit is not visible to the read.
  always_comb begin
    rd_mux = '0;
    unique case (bus.araddr[3:2])
      2'd0:    rd_mux = reg0_q;
      2'd1:    rd_mux = reg1_q;
      2'd2:    rd_mux = reg2_q;
      default: rd_mux = {wr_cnt_q, rd_cnt_q};
    endcase
  end

  // Enable flop: rises on the first clock edge after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      en_q <= 1'b0;
    end else begin
      en_q <= 1'b1;
    end
  end

  // Write path: latch AW/W in any order, commit once both are held,
  // then hold the response until the master takes it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_idx_q  <= 2'd0;
      wdata_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      reg0_q    <= '0;
      reg1_q    <= '0;
      reg2_q    <= '0;
      wr_cnt_q  <= 16'd0;
    end else begin
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_idx_q  <= bus.awaddr[3:2];
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        wdata_q  <= bus.wdata;
      end
      if (commit) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        if (aw_idx_q == IdxStatus) begin
          // Status word is read-only: reject without touching the counter.
          bresp_q <= RespSlverr;
        end else begin
          bresp_q  <= RespOkay;
          wr_cnt_q <= wr_cnt_q + 16'd1;
          unique case (aw_idx_q)
            2'd0:    reg0_q <= wdata_q;
            2'd1:    reg1_q <= wdata_q;
            default: reg2_q <= wdata_q;
          endcase
        end
      end else if (bvalid_q && bus.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read path: capture data on the AR handshake and hold it until taken.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rd_cnt_q <= 16'd0;
    end else begin
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end else if (rvalid_q && bus.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Bench for axi_lite_slave_regs: directed AXI4-Lite traffic, a behavioural
// register-file model compared every cycle, and literal spot checks.
module tb_axi_lite_slave_regs;

  logic        clk;
  logic        aresetn;
  logic [31:0] ctrl_out;
  logic        do_force;

  int checks = 0;
  int errors = 0;

  axi_lite_slave_regs_if bus ();

  axi_lite_slave_regs dut (
    .aclk     (clk),
    .aresetn  (aresetn),
    .bus      (bus),
    .ctrl_out (ctrl_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: registers, counters and one pending item per channel.
  // ---------------------------------------------------------------------------
  logic [31:0] m_reg [3];
  logic [15:0] m_wr_cnt, m_rd_cnt;
  logic        m_live;          // slave has seen a clock edge since reset
  logic        m_have_addr, m_have_data;
  logic [1:0]  m_addr_idx;
  logic [31:0] m_data;
  logic        m_resp_pending, m_read_pending;
  logic [1:0]  m_resp;
  logic [31:0] m_read_data;

  wire m_awready = m_live && !m_have_addr && !m_resp_pending;
  wire m_wready  = m_live && !m_have_data && !m_resp_pending;
  wire m_arready = m_live && !m_read_pending;

  function automatic logic [31:0] m_peek(input logic [1:0] idx);
    if (idx == 2'd3) return {m_wr_cnt, m_rd_cnt};
    return m_reg[idx];
  endfunction

  // Model update on each edge from the bench-driven inputs.
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_reg[0] <= '0; m_reg[1] <= '0; m_reg[2] <= '0;
      m_wr_cnt <= '0; m_rd_cnt <= '0; m_live <= 1'b0;
      m_have_addr <= 1'b0; m_have_data <= 1'b0; m_addr_idx <= '0; m_data <= '0;
      m_resp_pending <= 1'b0; m_resp <= 2'b00;
      m_read_pending <= 1'b0; m_read_data <= '0;
    end else begin
      m_live <= 1'b1;
      if (bus.awvalid && m_awready) begin
        m_have_addr <= 1'b1;
        m_addr_idx  <= bus.awaddr[3:2];
      end
      if (bus.wvalid && m_wready) begin
        m_have_data <= 1'b1;
        m_data      <= bus.wdata;
      end
      if (m_have_addr && m_have_data && !m_resp_pending) begin
        m_have_addr    <= 1'b0;
        m_have_data    <= 1'b0;
        m_resp_pending <= 1'b1;
        if (m_addr_idx == 2'd3) begin
          m_resp <= 2'b10;
        end else begin
          m_resp              <= 2'b00;
          m_reg[m_addr_idx]   <= m_data;
          m_wr_cnt            <= m_wr_cnt + 16'd1;
        end
      end else if (m_resp_pending && bus.bready) begin
        m_resp_pending <= 1'b0;
      end
      if (do_force) m_wr_cnt <= 16'hFFFF;
      if (bus.arvalid && m_arready) begin
        m_read_pending <= 1'b1;
        m_read_data    <= m_peek(bus.araddr[3:2]);
        m_rd_cnt       <= m_rd_cnt + 16'd1;
      end else if (m_read_pending && bus.rready) begin
        m_read_pending <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("awready", 32'(bus.awready), 32'(m_awready));
    check("wready", 32'(bus.wready), 32'(m_wready));
    check("arready", 32'(bus.arready), 32'(m_arready));
    check("bvalid", 32'(bus.bvalid), 32'(m_resp_pending));
    check("rvalid", 32'(bus.rvalid), 32'(m_read_pending));
    check("ctrl_out", ctrl_out, m_reg[0]);
    if (m_resp_pending) check("bresp", 32'(bus.bresp), 32'(m_resp));
    if (m_read_pending) begin
      check("rdata", bus.rdata, m_read_data);
      check("rresp", 32'(bus.rresp), 32'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, output logic [1:0] resp);
    int   t;
    logic aw_go, w_go;
    resp = 2'bxx;
    @(negedge clk);
    bus.awaddr = a; bus.wdata = d; bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    t = 0;
    while ((bus.awvalid || bus.wvalid) && t < 20) begin
      aw_go = bus.awvalid && bus.awready;
      w_go  = bus.wvalid && bus.wready;
      @(negedge clk);
      if (aw_go) bus.awvalid = 1'b0;
      if (w_go)  bus.wvalid  = 1'b0;
      t++;
    end
    if (t >= 20) begin
      timeout("write_addr_data");
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    end
    t = 0;
    while (!bus.bvalid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) timeout("write_resp");
    resp = bus.bresp;
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int t;
    d = 'x;
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
    t = 0;
    while (!bus.arready && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    bus.arvalid = 1'b0;
    if (t >= 20) timeout("read_addr");
    t = 0;
    while (!bus.rvalid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) timeout("read_data");
    d = bus.rdata;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  resp;
    aresetn = 1'b0; do_force = 1'b0;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset, then readies low for one cycle after release
    repeat (3) @(negedge clk);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_ctrl_out", ctrl_out, 32'h0);
    check("rst_bresp", 32'(bus.bresp), 32'h0);
    aresetn = 1'b1;
    #1;
    check("release_awready", 32'(bus.awready), 32'd0);
    check("release_arready", 32'(bus.arready), 32'd0);
    @(negedge clk);
    check("live_awready", 32'(bus.awready), 32'd1);
    check("live_wready", 32'(bus.wready), 32'd1);
    check("live_arready", 32'(bus.arready), 32'd1);

    // AW and W together to reg0
    axi_write(4'h0, 32'hDEADBEEF, resp);
    check("wr0_bresp", 32'(resp), 32'd0);
    check("wr0_ctrl_out", ctrl_out, 32'hDEADBEEF);
    axi_read(4'h0, rd);
    check("rd0", rd, 32'hDEADBEEF);

    // W three cycles ahead of AW to reg2, response back-pressured
    @(negedge clk);
    bus.bready = 1'b0; bus.wdata = 32'h12345678; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.wvalid = 1'b0;
    check("w_early_wready", 32'(bus.wready), 32'd0);
    repeat (2) @(negedge clk);
    bus.awaddr = 4'h8; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("hold_bvalid", 32'(bus.bvalid), 32'd1);
      check("hold_awready", 32'(bus.awready), 32'd0);
      check("hold_bresp", 32'(bus.bresp), 32'd0);
      @(negedge clk);
    end
    bus.bready = 1'b1;
    @(negedge clk);
    check("hold_released", 32'(bus.bvalid), 32'd0);

    // Write to the read-only status word
    axi_write(4'hC, 32'hFFFFFFFF, resp);
    check("wrC_bresp", 32'(resp), 32'd2);
    axi_read(4'hC, rd);
    check("rdC_counts", rd, 32'h00020001);
    axi_read(4'h8, rd);
    check("rd8", rd, 32'h12345678);

    // Commit to reg1 on the same edge as the AR to reg1
    @(negedge clk);
    bus.awaddr = 4'h4; bus.wdata = 32'hA5A5A5A5; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = 4'h4; bus.arvalid = 1'b1; bus.rready = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("race_rvalid", 32'(bus.rvalid), 32'd1);
    check("race_bvalid", 32'(bus.bvalid), 32'd1);
    check("race_rdata_old", bus.rdata, 32'h00000000);
    @(negedge clk);
    axi_read(4'h4, rd);
    check("rd4_new", rd, 32'hA5A5A5A5);

    // Write counter wrap
    @(negedge clk);
    force dut.wr_cnt_q = 16'hFFFF;
    do_force = 1'b1;
    @(negedge clk);
    release dut.wr_cnt_q;
    do_force = 1'b0;
    axi_write(4'h0, 32'h600DF00D, resp);
    check("wrap_bresp", 32'(resp), 32'd0);
    axi_read(4'hC, rd);
    check("wrap_counts", rd, 32'h00000005);

    // Reset while a response is outstanding
    @(negedge clk);
    bus.awaddr = 4'h8; bus.wdata = 32'hCAFE0000; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    bus.bready = 1'b0;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    check("pre_reset_bvalid", 32'(bus.bvalid), 32'd1);
    #2 aresetn = 1'b0;
    #1;
    check("async_bvalid", 32'(bus.bvalid), 32'd0);
    check("async_ctrl_out", ctrl_out, 32'h0);
    check("async_awready", 32'(bus.awready), 32'd0);
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    repeat (6) @(negedge clk);
    check("post_reset_bvalid", 32'(bus.bvalid), 32'd0);
    axi_read(4'h8, rd);
    check("post_reset_reg2", rd, 32'h0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
